max_pool_ctrl: RTL and testbench

- Sequencing controller for 2x2 max pooling, stride 2, over a streamed feature map.
- Accepts one pixel per cycle in raster order through a valid/ready handshake.
- Stores horizontal pair-maxima of each even row in a line buffer, then emits one pooled pixel per 2x2 window while the odd row streams in.
- Sits between the convolution output stream and the next layer; frames it with start/busy/done.

---
 rtl/max_pool_ctrl.sv | 157 +++++++++++++++
 tb/tb_max_pool_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/max_pool_ctrl.sv
// 2x2 / stride-2 max-pool sequencer over a raster pixel stream with valid/ready on both sides.
// Optional abort port enabled by defining MAX_POOL_CTRL_ABORT_EN.
module max_pool_ctrl #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef MAX_POOL_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
        $error("max_pool_ctrl: IMG_W must be even and >= 2");
    end
    if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
        $error("max_pool_ctrl: IMG_H must be even and >= 2");
    end

    localparam int HW = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
    localparam int CW = HW + 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, POOL, DRAIN} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] lbuf [IMG_W/2];

    logic              acc;
    logic              out_acc;
    logic              last_col;
    logic              last_row;
    logic [HW-1:0]     half;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] pool_max;
    logic              lbuf_we;
    logic              kill;

    function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

`ifdef MAX_POOL_CTRL_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            LOAD:    in_ready = 1'b1;
            POOL:    in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
        if (kill) in_ready = 1'b0;
    end

    assign acc      = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign half     = HW'(col >> 1);
    assign pair_max = vmax(hold, in_data);
    assign pool_max = vmax(pair_max, lbuf[half]);
    assign lbuf_we  = !reset && (state == LOAD) && acc && col[0];

    // Line buffer kept out of the reset domain: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (lbuf_we) lbuf[half] <= pair_max;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            hold      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_acc) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            if (acc) begin
                if (!col[0]) hold <= in_data;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (acc && last_col) state <= POOL;
                end
                POOL: begin
                    if (acc && col[0]) begin
                        out_data  <= pool_max;
                        out_valid <= 1'b1;
                        out_last  <= last_col && last_row;
                    end
                    if (acc && last_col) state <= last_row ? DRAIN : LOAD;
                end
                DRAIN: begin
                    if (out_acc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Abort overrides everything decided above in the same cycle.
            if (kill) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Directed self-checking bench for max_pool_ctrl (4x4 frame, 4-bit pixels).
module tb_max_pool_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef MAX_POOL_CTRL_ABORT_EN
    logic       abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] got_data [8];
    logic       got_last [8];
    int         ngot;
    int         ndone;
    int         last_out_cyc;
    int         done_cyc;

    max_pool_ctrl #(.DATA_W(4), .IMG_W(4), .IMG_H(4)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MAX_POOL_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("busy_after_start", int'(busy), 1);
    endtask

    // Feeds a whole frame; optionally stalls the first output and pulses start mid-frame.
    task automatic run_frame(input logic [3:0] px [16], input int stall_cnt, input int start_pix,
                             input logic [3:0] exp [4], input string name);
        int idx;
        int cyc;
        int stall_left;
        bit fin;
        idx = 0; cyc = 0; stall_left = stall_cnt; fin = 0;
        ngot = 0; ndone = 0; last_out_cyc = -100; done_cyc = -1;
        pulse_start();
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid  = (idx < 16);
            in_data   = (idx < 16) ? px[idx] : 4'd0;
            start     = (start_pix >= 0 && idx == start_pix);
            out_ready = 1'b1;
            if (stall_left > 0 && out_valid && ngot == 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (done) begin
                ndone++;
                done_cyc = cyc;
                check_eq({name, "_busy_at_done"}, int'(busy), 0);
                fin = 1;
            end
            if (!out_ready) begin
                check_eq({name, "_stall_hold"}, int'(out_data), int'(exp[0]));
                check_eq({name, "_stall_in_ready"}, int'(in_ready), 0);
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready && ngot < 8) begin
                got_data[ngot] = out_data;
                got_last[ngot] = out_last;
                ngot++;
                last_out_cyc = cyc;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check_eq({name, "_timeout"}, int'(fin), 1);
        check_eq({name, "_nout"}, ngot, 4);
        for (int k = 0; k < 4 && k < ngot; k++) begin
            check_eq($sformatf("%s_out%0d", name, k), int'(got_data[k]), int'(exp[k]));
            check_eq($sformatf("%s_last%0d", name, k), int'(got_last[k]), (k == 3) ? 1 : 0);
        end
        check_eq({name, "_done_lat"}, done_cyc - last_out_cyc, 1);
        @(negedge clk);
        #1;
        check_eq({name, "_done_once"}, int'(done), 0);
        check_eq({name, "_busy_end"}, int'(busy), 0);
    endtask

    // Starts a frame and feeds n pixels with downstream always ready.
    task automatic feed_n(input logic [3:0] px [16], input int n);
        int idx;
        int cyc;
        idx = 0; cyc = 0;
        pulse_start();
        while (idx < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            in_valid  = 1'b1;
            in_data   = px[idx];
            out_ready = 1'b1;
            #1;
            if (in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("feed_count", idx, n);
    endtask

    logic [3:0] px_basic [16] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                  4'd9, 4'd0, 4'd2, 4'd2, 4'd1, 4'd15, 4'd3, 4'd3};
    logic [3:0] px_sev   [16] = '{default: 4'd7};
    logic [3:0] px_one   [16] = '{12: 4'd15, default: 4'd0};
    logic [3:0] exp_basic [4] = '{4'd6, 4'd8, 4'd15, 4'd3};
    logic [3:0] exp_sev   [4] = '{4'd7, 4'd7, 4'd7, 4'd7};
    logic [3:0] exp_one   [4] = '{4'd0, 4'd0, 4'd15, 4'd0};

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef MAX_POOL_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", int'(in_ready), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_out_last", int'(out_last), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);

        run_frame(px_basic, 0, -1, exp_basic, "basic");
        run_frame(px_basic, 3, -1, exp_basic, "bp");
        run_frame(px_sev, 0, -1, exp_sev, "ties");
        run_frame(px_one, 0, -1, exp_one, "single15");
        run_frame(px_basic, 0, 5, exp_basic, "start_busy");

        feed_n(px_basic, 6);
        check_eq("pre_rst_out_valid", int'(out_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_in_ready", int'(in_ready), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        run_frame(px_basic, 0, -1, exp_basic, "after_rst");

`ifdef MAX_POOL_CTRL_ABORT_EN
        feed_n(px_basic, 6);
        check_eq("pre_abort_out_valid", int'(out_valid), 1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd7;
        #1;
        check_eq("abort_in_ready", int'(in_ready), 0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_in_ready_after", int'(in_ready), 0);
        run_frame(px_basic, 0, -1, exp_basic, "after_abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
